// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding and widths.
// Imported by the sequencer top and by its return-address stack.
package pc_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_INC  = 3'd1,
        OP_JMP  = 3'd2,
        OP_BR   = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Reserved codes behave exactly like NOP.
    function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of ADDR_W-bit link addresses.
// Only the occupancy counter is reset; the storage array is left as-is.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

    logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  top_cnt_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              full_s;
    logic              empty_s;
    logic              do_push_s;
    logic              do_pop_s;

    // Occupancy flags and guarded push/pop qualifiers.
    always_comb begin
        full_s    = (count_r == DEPTH_C);
        empty_s   = (count_r == ZERO_C);
        do_push_s = push && !full_s;
        do_pop_s  = pop && !empty_s;
        top_cnt_s = count_r - ONE_C;
        top_idx_s = top_cnt_s[IDX_W-1:0];
        wr_idx_s  = count_r[IDX_W-1:0];
    end

    // Storage write; a full stack never writes, so wr_idx_s stays in range.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_idx_s] <= push_data;
        end else begin
            mem_r[wr_idx_s] <= mem_r[wr_idx_s];
        end
    end

    // Occupancy counter; reset empties the stack so stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO_C;
        end else if (do_push_s) begin
            count_r <= count_r + ONE_C;
        end else if (do_pop_s) begin
            count_r <= count_r - ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign top   = mem_r[top_idx_s];
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: op decode, next-PC adder, sticky wrap flag and
// stack-error pulse around a return-address stack.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] offset,
    input  logic              clr_wrap,
    output logic [ADDR_W-1:0] pc,
    output logic              wrapped,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
);

    localparam logic [ADDR_W:0]   STEP_C  = (ADDR_W + 1)'(STEP);
    localparam logic [ADDR_W-1:0] RESET_C = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_r;
    logic              wrapped_r;
    logic              ras_err_r;

    logic [ADDR_W:0]   inc_sum_s;
    logic [ADDR_W:0]   br_sum_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              wrap_evt_s;
    logic              err_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic              ras_full_s;
    logic              ras_empty_s;

    // One extra bit on both adders: its MSB is the carry (or borrow when the
    // sign-extended offset is negative), the low bits are the wrapped result.
    always_comb begin
        inc_sum_s = {1'b0, pc_r} + STEP_C;
        br_sum_s  = {1'b0, pc_r} + {offset[ADDR_W-1], offset};
    end

    // Op decode; CALL uses the incremented PC only as link data, never as a wrap.
    always_comb begin
        next_pc_s  = pc_r;
        wrap_evt_s = 1'b0;
        err_s      = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        if (en && !op_is_reserved(op)) begin
            case (op)
                OP_INC: begin
                    next_pc_s  = inc_sum_s[ADDR_W-1:0];
                    wrap_evt_s = inc_sum_s[ADDR_W];
                end
                OP_JMP: begin
                    next_pc_s = target;
                end
                OP_BR: begin
                    next_pc_s  = br_sum_s[ADDR_W-1:0];
                    wrap_evt_s = br_sum_s[ADDR_W];
                end
                OP_CALL: begin
                    if (!ras_full_s) begin
                        push_s    = 1'b1;
                        next_pc_s = target;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!ras_empty_s) begin
                        pop_s     = 1'b1;
                        next_pc_s = ras_top_s;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    next_pc_s = pc_r;
                end
            endcase
        end else begin
            next_pc_s = pc_r;
        end
    end

    // PC, sticky wrap flag (set beats clear) and one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_C;
            wrapped_r <= 1'b0;
            ras_err_r <= 1'b0;
        end else begin
            pc_r      <= next_pc_s;
            ras_err_r <= err_s;
            if (wrap_evt_s) begin
                wrapped_r <= 1'b1;
            end else if (clr_wrap) begin
                wrapped_r <= 1'b0;
            end else begin
                wrapped_r <= wrapped_r;
            end
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (inc_sum_s[ADDR_W-1:0]),
        .top       (ras_top_s),
        .full      (ras_full_s),
        .empty     (ras_empty_s)
    );

    assign pc        = pc_r;
    assign wrapped   = wrapped_r;
    assign ras_err   = ras_err_r;
    assign ras_full  = ras_full_s;
    assign ras_empty = ras_empty_s;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: the driver queues hand-computed expectations,
// a monitor pops and compares them one step after each clock edge.
module tb_pc_seq;
    import pc_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [4:0] target;
    logic [4:0] offset;
    logic       clr_wrap;
    logic [4:0] pc;
    logic       wrapped;
    logic       ras_full;
    logic       ras_empty;
    logic       ras_err;

    typedef struct {
        logic [4:0] pc;
        logic       w;
        logic       f;
        logic       e;
        logic       err;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;

    pc_seq #(
        .ADDR_W    (5),
        .STEP      (1),
        .RAS_DEPTH (4),
        .RESET_VEC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .clr_wrap  (clr_wrap),
        .pc        (pc),
        .wrapped   (wrapped),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_err   (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled 1 time unit after the edge that consumed the op.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            n_checks++;
            if (pc === cur.pc && wrapped === cur.w && ras_full === cur.f &&
                ras_empty === cur.e && ras_err === cur.err) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got pc=%0d wrapped=%b full=%b empty=%b err=%b, want pc=%0d wrapped=%b full=%b empty=%b err=%b",
                         cur.nm, pc, wrapped, ras_full, ras_empty, ras_err,
                         cur.pc, cur.w, cur.f, cur.e, cur.err);
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] o,
                       input logic [4:0] t, input logic [4:0] off, input logic c,
                       input logic [4:0] epc, input logic ew, input logic ef,
                       input logic eem, input logic eer, input string nm);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        op       = o;
        target   = t;
        offset   = off;
        clr_wrap = c;
        x.pc = epc; x.w = ew; x.f = ef; x.e = eem; x.err = eer; x.nm = nm;
        exp_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; target = 5'd0; offset = 5'd0; clr_wrap = 1'b0;

        //  rst  en   op       target offset clr   pc  w  f  e  err
        cyc(1'b1, 1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
        for (int i = 1; i <= 31; i++)
            cyc(1'b0, 1'b1, OP_INC, 5'd0, 5'd0, 1'b0, 5'(i), 1'b0, 1'b0, 1'b1, 1'b0, "inc");
        cyc(1'b0, 1'b1, OP_INC,  5'd0,  5'd0,     1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, "inc_wrap");
        cyc(1'b0, 1'b1, OP_NOP,  5'd0,  5'd0,     1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, "clr_wrap");
        cyc(1'b0, 1'b1, OP_JMP,  5'd10, 5'd0,     1'b0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, "jmp");
        cyc(1'b0, 1'b1, OP_BR,   5'd0,  5'b11101, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, "br_minus3");
        // 5'b11110 is -2 as a signed displacement: no borrow past zero
        cyc(1'b0, 1'b1, OP_BR,   5'd0,  5'b11110, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, "br_minus2");
        cyc(1'b0, 1'b1, OP_JMP,  5'd20, 5'd0,     1'b0, 5'd20, 1'b0, 1'b0, 1'b1, 1'b0, "jmp20");
        cyc(1'b0, 1'b1, OP_BR,   5'd0,  5'd15,    1'b0, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, "br_pos_wrap");
        cyc(1'b0, 1'b1, OP_NOP,  5'd0,  5'd0,     1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, "clr2");
        cyc(1'b0, 1'b1, OP_BR,   5'd0,  5'b11010, 1'b0, 5'd29, 1'b1, 1'b0, 1'b1, 1'b0, "br_borrow");
        cyc(1'b0, 1'b0, OP_INC,  5'd0,  5'd0,     1'b1, 5'd29, 1'b0, 1'b0, 1'b1, 1'b0, "clr_en_low");
        cyc(1'b0, 1'b1, OP_JMP,  5'd3,  5'd0,     1'b0, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, "jmp3");
        cyc(1'b0, 1'b1, OP_CALL, 5'd20, 5'd0,     1'b0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0, "call");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0, "ret");
        cyc(1'b0, 1'b1, OP_CALL, 5'd8,  5'd0,     1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, "call1");
        cyc(1'b0, 1'b1, OP_CALL, 5'd12, 5'd0,     1'b0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, "call2");
        cyc(1'b0, 1'b1, OP_CALL, 5'd16, 5'd0,     1'b0, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0, "call3");
        cyc(1'b0, 1'b1, OP_CALL, 5'd24, 5'd0,     1'b0, 5'd24, 1'b0, 1'b1, 1'b0, 1'b0, "call4_full");
        cyc(1'b0, 1'b1, OP_CALL, 5'd30, 5'd0,     1'b0, 5'd24, 1'b0, 1'b1, 1'b0, 1'b1, "call_overflow");
        cyc(1'b0, 1'b1, OP_NOP,  5'd0,  5'd0,     1'b0, 5'd24, 1'b0, 1'b1, 1'b0, 1'b0, "err_one_cycle");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0, "ret1");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, "ret2");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, "ret3");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, "ret4");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, "ret_underflow");
        cyc(1'b0, 1'b0, OP_INC,  5'd0,  5'd0,     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, "en_low_inc");
        cyc(1'b0, 1'b0, OP_CALL, 5'd9,  5'd0,     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, "en_low_call");
        cyc(1'b0, 1'b1, OP_RSV6, 5'd9,  5'd0,     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, "rsv6");
        cyc(1'b0, 1'b1, OP_RSV7, 5'd9,  5'd0,     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, "rsv7");
        cyc(1'b0, 1'b1, OP_JMP,  5'd31, 5'd0,     1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, "jmp31");
        cyc(1'b0, 1'b1, OP_CALL, 5'd2,  5'd0,     1'b0, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, "call_link_nowrap");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, "ret_link0");
        cyc(1'b0, 1'b1, OP_JMP,  5'd31, 5'd0,     1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, "jmp31b");
        cyc(1'b0, 1'b1, OP_INC,  5'd0,  5'd0,     1'b1, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, "wrap_vs_clr");
        cyc(1'b0, 1'b1, OP_CALL, 5'd6,  5'd0,     1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, "callA");
        cyc(1'b0, 1'b1, OP_CALL, 5'd9,  5'd0,     1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, "callB");
        cyc(1'b1, 1'b1, OP_INC,  5'd0,  5'd0,     1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, "rst_mid");
        cyc(1'b0, 1'b1, OP_RET,  5'd0,  5'd0,     1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, "ret_after_rst");
        cyc(1'b0, 1'b1, OP_NOP,  5'd0,  5'd0,     1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, "idle");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
